sonar_scheduler: RTL and testbench

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

---
 rtl/sonar_scheduler.sv | 157 +++++++++++++++
 tb/tb_sonar_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin HC-SR04 scan scheduler sharing one ranging engine
module sonar_scheduler #(
    parameter int NCH         = 4,
    parameter int TIMEOUT_CYC = 4_000_000,
    parameter int GUARD_CYC   = 6_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [NCH-1:0]     ch_mask,
    output logic               eng_measure,
    input  logic               eng_ready,
    output logic               eng_rst,
    input  logic               eng_trig,
    output logic               eng_echo,
    input  logic [21:0]        eng_dist,
    output logic [NCH-1:0]     trig_o,
    input  logic [NCH-1:0]     echo_i,
    output logic [NCH*22-1:0]  dist_o,
    output logic [NCH-1:0]     valid_o,
    output logic [NCH-1:0]     timeout_o,
    output logic [2:0]         cur_ch,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_GUARD} state_t;

    localparam logic [22:0] TO_LAST = 23'(TIMEOUT_CYC - 1);
    localparam logic [22:0] GD_LAST = 23'(GUARD_CYC - 1);

    state_t                r_state;
    logic [22:0]           r_timer;
    logic                  r_seen_busy;
    logic [2:0]            r_last;
    logic [2:0]            r_cur;
    logic [NCH-1:0][21:0]  r_dist;
    logic [NCH-1:0]        r_valid;
    logic [NCH-1:0]        r_timeout;
    logic                  r_done;
    logic                  r_measure;
    logic                  r_eng_rst;

    logic                  w_found;
    logic [2:0]            w_next;
    logic                  w_route;

    // First masked-in channel strictly after the last one served, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_next  = r_last;
        for (int i = 1; i <= NCH; i++) begin
            for (int k = 0; k < NCH; k++) begin
                if (!w_found && ch_mask[k] && (((int'(r_last) + i) % NCH) == k)) begin
                    w_found = 1'b1;
                    w_next  = 3'(k);
                end
            end
        end
    end

    always_comb begin
        w_route  = (r_state == S_START) || (r_state == S_BUSY);
        trig_o   = '0;
        eng_echo = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (w_route && (r_cur == 3'(k))) begin
                trig_o[k] = eng_trig;
                eng_echo  = echo_i[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_seen_busy <= 1'b0;
            r_last      <= 3'(NCH - 1);
            r_cur       <= '0;
            r_dist      <= '0;
            r_valid     <= '0;
            r_timeout   <= '0;
            r_done      <= 1'b0;
            r_measure   <= 1'b0;
            r_eng_rst   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_measure <= 1'b0;
            r_eng_rst <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && w_found) begin
                        r_cur   <= w_next;
                        r_last  <= w_next;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (eng_ready) begin
                        r_measure   <= 1'b1;
                        r_timer     <= '0;
                        r_seen_busy <= 1'b0;
                        r_state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_timer <= r_timer + 23'd1;
                    if (!eng_ready) begin
                        r_seen_busy <= 1'b1;
                    end
                    // A completion seen on the final timeout cycle still counts as good.
                    if (r_seen_busy && eng_ready) begin
                        for (int k = 0; k < NCH; k++) begin
                            if (r_cur == 3'(k)) begin
                                r_dist[k]    <= eng_dist;
                                r_valid[k]   <= 1'b1;
                                r_timeout[k] <= 1'b0;
                            end
                        end
                        r_done  <= 1'b1;
                        r_timer <= '0;
                        r_state <= S_GUARD;
                    end else if (r_timer == TO_LAST) begin
                        for (int k = 0; k < NCH; k++) begin
                            if (r_cur == 3'(k)) begin
                                r_valid[k]   <= 1'b0;
                                r_timeout[k] <= 1'b1;
                            end
                        end
                        r_eng_rst <= 1'b1;
                        r_done    <= 1'b1;
                        r_timer   <= '0;
                        r_state   <= S_GUARD;
                    end
                end
                S_GUARD: begin
                    if (r_timer == GD_LAST) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 23'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign eng_measure = r_measure;
    assign eng_rst     = r_eng_rst;
    assign dist_o      = r_dist;
    assign valid_o     = r_valid;
    assign timeout_o   = r_timeout;
    assign cur_ch      = r_cur;
    assign done        = r_done;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb/tb_sonar_scheduler.sv - randomized scheduler bench with engine/sensor models and a scan reference model
`timescale 1ns/1ps
module tb_sonar_scheduler;

    localparam int NCH      = 4;
    localparam int TO       = 2000;
    localparam int GD       = 500;
    localparam int TRIG_LEN = 10;
    localparam int ECHO_DLY = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic [NCH-1:0]     ch_mask = '0;
    logic               eng_measure, eng_ready, eng_rst, eng_trig, eng_echo;
    logic [21:0]        eng_dist;
    logic [NCH-1:0]     trig_o, echo_i, valid_o, timeout_o;
    logic [NCH*22-1:0]  dist_o;
    logic [2:0]         cur_ch;
    logic               done;

    sonar_scheduler #(.NCH(NCH), .TIMEOUT_CYC(TO), .GUARD_CYC(GD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .eng_measure(eng_measure), .eng_ready(eng_ready), .eng_rst(eng_rst),
        .eng_trig(eng_trig), .eng_echo(eng_echo), .eng_dist(eng_dist),
        .trig_o(trig_o), .echo_i(echo_i), .dist_o(dist_o), .valid_o(valid_o),
        .timeout_o(timeout_o), .cur_ch(cur_ch), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ranging engine: 10-cycle trigger, then counts echo-high cycles.
    int          e_st, e_cnt;
    logic [21:0] e_dist;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e_st <= 0; e_cnt <= 0; e_dist <= '0;
        end else if (eng_rst) begin
            e_st <= 0;
        end else begin
            case (e_st)
                0: if (eng_measure) begin e_st <= 1; e_cnt <= 0; end
                1: if (e_cnt == TRIG_LEN - 1) e_st <= 2; else e_cnt <= e_cnt + 1;
                2: if (eng_echo) begin e_st <= 3; e_cnt <= 1; end
                default: if (eng_echo) e_cnt <= e_cnt + 1;
                         else begin e_dist <= 22'(e_cnt); e_st <= 0; end
            endcase
        end
    end
    assign eng_ready = (e_st == 0);
    assign eng_trig  = (e_st == 1);
    assign eng_dist  = e_dist;

    // Sensors: after a trigger falls, wait ECHO_DLY then echo for echo_len cycles (0 = never).
    int             echo_len [NCH];
    int             s_ph [NCH];
    int             s_cnt [NCH];
    logic [NCH-1:0] s_echo, s_prev, noise, noise_ch;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_echo <= '0; s_prev <= '0;
            for (int k = 0; k < NCH; k++) begin s_ph[k] <= 0; s_cnt[k] <= 0; end
        end else begin
            s_prev <= trig_o;
            for (int k = 0; k < NCH; k++) begin
                case (s_ph[k])
                    0: if (s_prev[k] && !trig_o[k] && echo_len[k] > 0) begin
                           s_ph[k] <= 1; s_cnt[k] <= ECHO_DLY;
                       end
                    1: if (s_cnt[k] == 1) begin
                           s_ph[k] <= 2; s_cnt[k] <= echo_len[k]; s_echo[k] <= 1'b1;
                       end else s_cnt[k] <= s_cnt[k] - 1;
                    default: if (s_cnt[k] == 1) begin
                           s_echo[k] <= 1'b0; s_ph[k] <= 0;
                       end else s_cnt[k] <= s_cnt[k] - 1;
                endcase
            end
        end
    end
    always @(posedge clk) noise <= noise_ch & NCH'($urandom);
    assign echo_i = s_echo | noise;

    // Reference model of per-channel results and round-robin position.
    logic [21:0]    m_dist [NCH];
    logic [NCH-1:0] m_valid, m_to;
    int             m_last, last_done;
    bit             have_done;

    function automatic int rr_next(input logic [NCH-1:0] m, input int last);
        for (int i = 1; i <= NCH; i++) begin
            if (m[(last + i) % NCH]) return (last + i) % NCH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) m_dist[k] = '0;
        m_valid = '0; m_to = '0; m_last = NCH - 1; have_done = 0;
    endtask

    task automatic do_measure(input bit drop_en);
        int exp_ch, t, meas_cyc, n_meas, n_rst, viol, dcyc;
        bit to_exp;
        logic [NCH*22-1:0] exp_vec;
        exp_ch = rr_next(ch_mask, m_last);
        t = 0; viol = 0;
        @(negedge clk);
        while (!eng_measure && t < GD + 100) begin
            if (trig_o !== '0 || done !== 1'b0 || eng_echo !== 1'b0) viol++;
            @(negedge clk); t++;
        end
        checks++;
        if (!eng_measure) begin
            errors++;
            $display("FAIL measure_start: no eng_measure in %0d cycles, required a pulse for ch%0d", t, exp_ch);
            return;
        end
        checks++;
        if (cur_ch !== 3'(exp_ch)) begin
            errors++; $display("FAIL service_order: cur_ch=%0d required %0d", cur_ch, exp_ch);
        end
        if (have_done) begin
            checks++;
            if (cyc - last_done < GD) begin
                errors++; $display("FAIL guard_gap: %0d cycles done->measure, required >= %0d", cyc - last_done, GD);
            end
        end
        meas_cyc = cyc; n_meas = 0; n_rst = 0; t = 0;
        if (drop_en) enable = 1'b0;
        do begin
            @(negedge clk); t++;
            if (eng_measure) n_meas++;
            if (eng_rst) n_rst++;
            if ((trig_o & ~(NCH'(1) << exp_ch)) !== '0 || trig_o[exp_ch] !== eng_trig) viol++;
            if (!done && eng_echo !== echo_i[exp_ch]) viol++;
        end while (!done && t < TO + 100);
        checks++;
        if (!done) begin
            errors++; $display("FAIL done_missing: no done within %0d cycles for ch%0d", t, exp_ch);
            return;
        end
        dcyc = cyc;
        to_exp = (echo_len[exp_ch] == 0);
        if (to_exp) begin
            checks++;
            if (dcyc - meas_cyc != TO) begin
                errors++; $display("FAIL timeout_latency: %0d busy cycles, required %0d", dcyc - meas_cyc, TO);
            end
            m_valid[exp_ch] = 1'b0; m_to[exp_ch] = 1'b1;
        end else begin
            m_dist[exp_ch] = 22'(echo_len[exp_ch]); m_valid[exp_ch] = 1'b1; m_to[exp_ch] = 1'b0;
        end
        checks++;
        if (n_rst != (to_exp ? 1 : 0)) begin
            errors++; $display("FAIL eng_rst_pulses: %0d required %0d", n_rst, to_exp ? 1 : 0);
        end
        checks++;
        if (n_meas != 0) begin
            errors++; $display("FAIL measure_width: %0d extra measure cycles, required 0", n_meas);
        end
        checks++;
        if (viol != 0) begin
            errors++; $display("FAIL routing: %0d trig/echo routing violations, required 0", viol);
        end
        for (int k = 0; k < NCH; k++) exp_vec[k*22 +: 22] = m_dist[k];
        checks++;
        if (dist_o !== exp_vec) begin
            errors++; $display("FAIL dist: dist_o=%h required %h", dist_o, exp_vec);
        end
        checks++;
        if (valid_o !== m_valid || timeout_o !== m_to) begin
            errors++; $display("FAIL flags: valid=%b timeout=%b required valid=%b timeout=%b",
                               valid_o, timeout_o, m_valid, m_to);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL done_width: done=%b one cycle after pulse, required 0", done);
        end
        m_last = exp_ch; last_done = dcyc; have_done = 1;
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b1; enable = 1'b0; ch_mask = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (dist_o !== '0 || valid_o !== '0 || timeout_o !== '0) begin
            errors++; $display("FAIL reset_results: dist=%h valid=%b timeout=%b required 0", dist_o, valid_o, timeout_o);
        end
        checks++;
        if (done !== 1'b0 || eng_measure !== 1'b0 || eng_rst !== 1'b0 || cur_ch !== 3'd0 || trig_o !== '0) begin
            errors++; $display("FAIL reset_ctrl: done=%b meas=%b erst=%b cur=%0d trig=%b required 0",
                               done, eng_measure, eng_rst, cur_ch, trig_o);
        end
        rst = 1'b0; ch_mask = '1; seen = 0;
        repeat (40) begin @(negedge clk); if (eng_measure) seen++; end
        enable = 1'b1; ch_mask = '0;
        repeat (40) begin @(negedge clk); if (eng_measure) seen++; end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL idle_hold: %0d measure pulses while disabled or mask empty, required 0", seen);
        end
    endtask

    task automatic test_single();
        for (int k = 0; k < NCH; k++) echo_len[k] = $urandom_range(1500, 100);
        echo_len[0] = 1450;
        ch_mask = '1; enable = 1'b1;
        do_measure(1'b1);
        checks++;
        if (dist_o[21:0] !== 22'd1450 || valid_o[0] !== 1'b1) begin
            errors++; $display("FAIL single_ch0: dist=%0d valid=%b required 1450 1", dist_o[21:0], valid_o[0]);
        end
    endtask

    task automatic test_enable_drop();
        int seen;
        enable = 1'b1;
        do_measure(1'b1);
        seen = 0;
        repeat (GD + 100) begin @(negedge clk); if (eng_measure || done) seen++; end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL enable_drop_idle: %0d activity cycles after guard, required 0", seen);
        end
    endtask

    task automatic test_scan_alternating();
        ch_mask = 4'b1010; noise_ch = 4'b0101;
        enable = 1'b1;
        for (int n = 0; n < 6; n++) begin
            echo_len[1] = $urandom_range(1500, 100);
            echo_len[3] = $urandom_range(1500, 100);
            do_measure(1'b0);
        end
        noise_ch = '0;
    endtask

    task automatic test_timeout();
        ch_mask = 4'b0100;
        echo_len[2] = $urandom_range(1500, 100);
        do_measure(1'b0);
        ch_mask = 4'b1100;
        echo_len[2] = 0;
        echo_len[3] = $urandom_range(1500, 100);
        do_measure(1'b0);
        do_measure(1'b0);
        do_measure(1'b0);
    endtask

    task automatic test_reset_mid_busy();
        int t, seen;
        ch_mask = '1; enable = 1'b1;
        for (int k = 0; k < NCH; k++) echo_len[k] = $urandom_range(1500, 100);
        t = 0;
        while (!eng_measure && t < GD + 100) begin @(negedge clk); t++; end
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dist_o !== '0 || valid_o !== '0 || timeout_o !== '0 || cur_ch !== 3'd0) begin
            errors++; $display("FAIL async_reset_results: dist=%h valid=%b timeout=%b cur=%0d required 0",
                               dist_o, valid_o, timeout_o, cur_ch);
        end
        checks++;
        if (trig_o !== '0 || eng_echo !== 1'b0 || done !== 1'b0 || eng_measure !== 1'b0) begin
            errors++; $display("FAIL async_reset_ctrl: trig=%b echo=%b done=%b meas=%b required 0",
                               trig_o, eng_echo, done, eng_measure);
        end
        seen = 0;
        repeat (4) begin @(negedge clk); if (done) seen++; end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_done: %0d done pulses in reset, required 0", seen);
        end
        rst = 1'b0;
        model_reset();
        do_measure(1'b1);
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) echo_len[k] = 0;
        noise_ch = '0;
        model_reset();
        test_reset();
        test_single();
        test_enable_drop();
        test_scan_alternating();
        test_timeout();
        test_reset_mid_busy();
        enable = 1'b0;
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
